mnist_class_evaluator: RTL

//  Synthesizable, parametrised scorer for channel-multiplexed binary classifier outputs.

---
 rtl/mnist_class_evaluator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mnist_class_evaluator.sv
// mnist_class_evaluator: per-class vote popcount, registered argmax and accuracy counters.
// Define MNIST_EVAL_PER_CLASS_EN to build the per-label counters behind class_ok/class_total.
module mnist_class_evaluator #(
  parameter int CLASS_NUM     = 10,
  parameter int CHANNEL_NUM   = 1,
  parameter int USER_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 32,
  localparam int SCORE_WIDTH  = $clog2(CHANNEL_NUM + 1),
  localparam int CLASS_WIDTH  = ($clog2(CLASS_NUM) > 1) ? $clog2(CLASS_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cke,
  input  logic                               clear,
  input  logic                               s_last,
  input  logic [USER_WIDTH-1:0]              s_user,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0]   s_data,
  input  logic                               s_valid,
  output logic [CLASS_WIDTH-1:0]             m_class,
  output logic                               m_none,
  output logic                               m_match,
  output logic [USER_WIDTH-1:0]              m_user,
  output logic                               m_last,
  output logic                               m_valid,
  output logic [COUNTER_WIDTH-1:0]           total_count,
  output logic [COUNTER_WIDTH-1:0]           ok_count,
  output logic                               done,
  output logic [CLASS_NUM*COUNTER_WIDTH-1:0] class_ok,
  output logic [CLASS_NUM*COUNTER_WIDTH-1:0] class_total
);

  localparam int CMP_W = (USER_WIDTH > CLASS_WIDTH) ? USER_WIDTH : CLASS_WIDTH;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v,
                                                       input logic inc);
    if (inc && (v != {COUNTER_WIDTH{1'b1}}))
      return v + COUNTER_WIDTH'(1);
    return v;
  endfunction

  logic [SCORE_WIDTH-1:0] score_p0 [CLASS_NUM];
  logic [SCORE_WIDTH-1:0] score_p1 [CLASS_NUM];
  logic [USER_WIDTH-1:0]  user_p1, user_p2;
  logic                   last_p1, last_p2;
  logic                   vld_p1, vld_p2;
  logic [CLASS_WIDTH-1:0] class_p1, class_p2;
  logic [SCORE_WIDTH-1:0] best_p1;
  logic                   none_p1, none_p2;
  logic                   match_p1, match_p2;
  logic [COUNTER_WIDTH-1:0] total_q, ok_q;
  logic                   done_q;
  logic                   count_en;

  always_comb begin
    for (int k = 0; k < CLASS_NUM; k++) begin
      score_p0[k] = '0;
      for (int c = 0; c < CHANNEL_NUM; c++)
        score_p0[k] = score_p0[k] + SCORE_WIDTH'(s_data[c*CLASS_NUM+k]);
    end
  end

  // ---- stage 1: registered per-class scores ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CLASS_NUM; k++) score_p1[k] <= '0;
      user_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (cke) begin
      for (int k = 0; k < CLASS_NUM; k++) score_p1[k] <= score_p0[k];
      user_p1 <= s_user;
      last_p1 <= s_last;
      vld_p1  <= s_valid;
    end
  end

  // strict '>' scan from index 0 keeps the lowest index on ties; all-zero leaves class 0
  always_comb begin
    class_p1 = '0;
    best_p1  = score_p1[0];
    for (int k = 1; k < CLASS_NUM; k++) begin
      if (score_p1[k] > best_p1) begin
        best_p1  = score_p1[k];
        class_p1 = CLASS_WIDTH'(k);
      end
    end
    none_p1  = (best_p1 == '0);
    match_p1 = !none_p1 && (CMP_W'(user_p1) == CMP_W'(class_p1));
  end

  // ---- stage 2: registered argmax result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      class_p2 <= '0;
      none_p2  <= 1'b0;
      match_p2 <= 1'b0;
      user_p2  <= '0;
      last_p2  <= 1'b0;
      vld_p2   <= 1'b0;
    end else if (cke) begin
      class_p2 <= class_p1;
      none_p2  <= none_p1;
      match_p2 <= match_p1;
      user_p2  <= user_p1;
      last_p2  <= last_p1;
      vld_p2   <= vld_p1;
    end
  end

  assign m_class = class_p2;
  assign m_none  = none_p2;
  assign m_match = match_p2;
  assign m_user  = user_p2;
  assign m_last  = last_p2;
  assign m_valid = vld_p2;

  // ---- stage 3: accumulation of the emitted result ----
  assign count_en = vld_p2 && !done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
      ok_q    <= '0;
      done_q  <= 1'b0;
    end else if (cke) begin
      if (clear) begin
        total_q <= '0;
        ok_q    <= '0;
        done_q  <= 1'b0;
      end else if (count_en) begin
        total_q <= sat_inc(total_q, 1'b1);
        ok_q    <= sat_inc(ok_q, match_p2);
        if (last_p2) done_q <= 1'b1;
      end
    end
  end

  assign total_count = total_q;
  assign ok_count    = ok_q;
  assign done        = done_q;

`ifdef MNIST_EVAL_PER_CLASS_EN
  logic [COUNTER_WIDTH-1:0] cls_ok_q  [CLASS_NUM];
  logic [COUNTER_WIDTH-1:0] cls_tot_q [CLASS_NUM];
  logic [CLASS_NUM-1:0]     hit_p2;

  // out-of-range labels hit no entry
  always_comb begin
    hit_p2 = '0;
    for (int k = 0; k < CLASS_NUM; k++)
      hit_p2[k] = (CMP_W'(user_p2) == CMP_W'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CLASS_NUM; k++) begin
        cls_ok_q[k]  <= '0;
        cls_tot_q[k] <= '0;
      end
    end else if (cke) begin
      for (int k = 0; k < CLASS_NUM; k++) begin
        if (clear) begin
          cls_ok_q[k]  <= '0;
          cls_tot_q[k] <= '0;
        end else if (count_en && hit_p2[k]) begin
          cls_tot_q[k] <= sat_inc(cls_tot_q[k], 1'b1);
          cls_ok_q[k]  <= sat_inc(cls_ok_q[k], match_p2);
        end
      end
    end
  end

  for (genvar k = 0; k < CLASS_NUM; k++) begin : g_cls_out
    assign class_ok[k*COUNTER_WIDTH +: COUNTER_WIDTH]    = cls_ok_q[k];
    assign class_total[k*COUNTER_WIDTH +: COUNTER_WIDTH] = cls_tot_q[k];
  end
`else
  assign class_ok    = '0;
  assign class_total = '0;
`endif

endmodule
